cam_sccb_init: RTL

Configures the OV7670 camera over its SCCB (I2C-like) bus before image capture begins. The block plays a fixed register table: soft reset, then RGB444 output and QQVGA (160x120) scaling with the pixel clock divided by 4. This produces the 12-bit pixel stream that the capture stage writes into the dual-port frame buffer. It sits upstream of the capture path, beside the camera clock/pwdn/reset pins, and has no data interface to the capture stage.

---
 rtl/cam_cfg_pkg.sv | 36 +++
 rtl/sccb_ctrl_rom.sv | 12 +
 rtl/cam_sccb_init.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cam_cfg_pkg.sv
// OV7670 configuration constants: FSM states, SCCB ID, delay marker
// and the RGB444 / QQVGA register table.
package cam_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_BIT,
        S_STOP,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] SCCB_ID    = 8'h42;
    localparam logic [7:0] DELAY_MARK = 8'hFF;
    localparam int         NUM_REGS   = 9;

    // {addr, data}; the FF entry waits out the soft reset
    function automatic logic [15:0] cfg_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h1280;
            4'd1:    return 16'hFF00;
            4'd2:    return 16'h1204;
            4'd3:    return 16'h8C02;
            4'd4:    return 16'h40D0;
            4'd5:    return 16'h3E1A;
            4'd6:    return 16'h0C04;
            4'd7:    return 16'h7222;
            4'd8:    return 16'h73F2;
            default: return 16'hFF00;
        endcase
    endfunction

endpackage

// File: rtl/sccb_ctrl_rom.sv
// Register table lookup; swap this file to select another camera mode.
module sccb_ctrl_rom
    import cam_cfg_pkg::*;
(
    input  logic [3:0] idx,
    output logic [7:0] addr,
    output logic [7:0] data
);

    assign {addr, data} = cfg_entry(idx);

endmodule

// File: rtl/cam_sccb_init.sv
// Plays the OV7670 register table over SCCB once per start request.
// All pins are registered from the next-state values.
module cam_sccb_init
    import cam_cfg_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int SCCB_FREQ = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       sioc,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic [3:0] reg_idx
);

    localparam int Q         = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int DELAY_CYC = CLK_FREQ / 1000;
    localparam int QW        = (Q > 1) ? $clog2(Q) : 1;
    localparam int DW        = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;

    localparam logic [QW-1:0] Q_LAST   = QW'(Q - 1);
    localparam logic [DW-1:0] D_LAST   = DW'(DELAY_CYC - 1);
    localparam logic [3:0]    IDX_LAST = 4'(NUM_REGS - 1);

    state_t          state, state_n;
    logic [QW-1:0]   q_cnt, q_n;
    logic [1:0]      qi, qi_n;
    logic [4:0]      bit_cnt, bit_n;
    logic [DW-1:0]   dly, dly_n;
    logic [3:0]      idx_n;
    logic [7:0]      addr_q, addr_n;
    logic [7:0]      data_q, data_n;
    logic [7:0]      rom_addr, rom_data;
    logic [26:0]     frame_n;
    logic            tick, fin;
    logic            sioc_n, oe_n, busy_n, done_n;

    sccb_ctrl_rom u_rom (
        .idx  (reg_idx),
        .addr (rom_addr),
        .data (rom_data)
    );

    assign tick = (q_cnt == Q_LAST);

    always_comb begin
        state_n = state;
        q_n     = q_cnt;
        qi_n    = qi;
        bit_n   = bit_cnt;
        dly_n   = dly;
        idx_n   = reg_idx;
        addr_n  = addr_q;
        data_n  = data_q;
        fin     = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_LOAD;
                    idx_n   = 4'd0;
                end
            end
            S_LOAD: begin
                addr_n  = rom_addr;
                data_n  = rom_data;
                q_n     = '0;
                qi_n    = 2'd0;
                bit_n   = 5'd0;
                dly_n   = '0;
                state_n = (rom_addr == DELAY_MARK) ? S_WAIT : S_START;
            end
            S_WAIT: begin
                if (dly == D_LAST) fin = 1'b1;
                else               dly_n = dly + DW'(1);
            end
            default: begin
                // START / BIT / STOP / GAP share the quarter-bit timebase
                if (!tick) begin
                    q_n = q_cnt + QW'(1);
                end else begin
                    q_n  = '0;
                    qi_n = qi + 2'd1;
                    case (state)
                        S_START: if (qi == 2'd1) begin
                            state_n = S_BIT;
                            qi_n    = 2'd0;
                        end
                        S_BIT: if (qi == 2'd3) begin
                            if (bit_cnt == 5'd26) state_n = S_STOP;
                            else                  bit_n = bit_cnt + 5'd1;
                        end
                        S_STOP: if (qi == 2'd2) begin
                            state_n = S_GAP;
                            qi_n    = 2'd0;
                        end
                        S_GAP: if (qi == 2'd3) fin = 1'b1;
                        default: ;
                    endcase
                end
            end
        endcase

        if (fin) begin
            if (reg_idx == IDX_LAST) begin
                state_n = S_DONE;
            end else begin
                state_n = S_LOAD;
                idx_n   = reg_idx + 4'd1;
            end
        end
    end

    // ack slots carry a 1 so SIOD is released there
    assign frame_n = {SCCB_ID, 1'b1, addr_n, 1'b1, data_n, 1'b1};

    always_comb begin
        sioc_n = 1'b1;
        oe_n   = 1'b0;
        case (state_n)
            S_START: begin
                sioc_n = (qi_n == 2'd0);
                oe_n   = 1'b1;
            end
            S_BIT: begin
                sioc_n = qi_n[1];
                oe_n   = ~frame_n[5'd26 - bit_n];
            end
            S_STOP: begin
                sioc_n = (qi_n != 2'd0);
                oe_n   = (qi_n != 2'd2);
            end
            default: ;
        endcase
        busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
        done_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            q_cnt   <= '0;
            qi      <= 2'd0;
            bit_cnt <= 5'd0;
            dly     <= '0;
            reg_idx <= 4'd0;
            addr_q  <= 8'd0;
            data_q  <= 8'd0;
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            q_cnt   <= q_n;
            qi      <= qi_n;
            bit_cnt <= bit_n;
            dly     <= dly_n;
            reg_idx <= idx_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            sioc    <= sioc_n;
            siod_oe <= oe_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule
